program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 20 ++
 rtl/program_loader_if.sv | 29 ++
 rtl/program_loader_timeout_ctr.sv | 31 +++
 rtl/program_loader.sv | 176 +++++++++++++++++
 tb/tb_program_loader.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the UART program loader.
// The CSUM state exists only when LOADER_CHECKSUM_EN is defined.
package program_loader_pkg;

    localparam int IMEM_DEPTH_DEFAULT     = 32;
    localparam int IMEM_AW                = $clog2(IMEM_DEPTH_DEFAULT);
    localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERROR
    } load_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory bus of the program loader.
// slave is the loader side, master is the UART / core side.
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int AW = IMEM_AW
) ();

    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          reload;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_loaded;

    modport slave (
        input  rx_valid, rx_data, reload,
        output imem_we, imem_addr, imem_wdata, load_done, load_error, words_loaded
    );

    modport master (
        output rx_valid, rx_data, reload,
        input  imem_we, imem_addr, imem_wdata, load_done, load_error, words_loaded
    );

endinterface

// File: rtl/program_loader_timeout_ctr.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags
// expiry once TIMEOUT_CYCLES consecutive cycles pass without a clear.
module loader_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // expiry is seen in the cycle that would complete the TIMEOUT_CYCLES-th idle cycle
    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

    // count idle cycles; the counter rests at zero whenever it is not armed
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a word count, then N big-endian 16-bit words
// from a UART byte stream and writes them into instruction memory.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int IMEM_DEPTH     = IMEM_DEPTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             CLK,
    input  logic             RST,
    program_loader_if.slave  bus
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int WW = AW + 1;

    load_state_t   state;
    load_state_t   next_state;

    logic [7:0]    count_n;
    logic [7:0]    hi_byte;
    logic [WW-1:0] words_loaded_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   wdata_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    logic          accept_count;
    logic          latch_hi;
    logic          write_word;
    logic          last_word;
    logic          timer_enable;
    logic          timer_clear;
    logic          timer_expired;

    assign last_word   = (int'(words_loaded_q) == int'(count_n) - 1);
    assign timer_clear = bus.rx_valid || bus.reload || ((next_state == HI) && (state != HI));

    loader_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (CLK),
        .rst     (RST),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state decode and datapath strobes; a received byte beats a same-cycle timeout
    always_comb begin
        next_state   = state;
        accept_count = 1'b0;
        latch_hi     = 1'b0;
        write_word   = 1'b0;
        timer_enable = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    if ((bus.rx_data == 8'd0) || (int'(bus.rx_data) > IMEM_DEPTH)) begin
                        next_state = ERROR;
                    end else begin
                        accept_count = 1'b1;
                        next_state   = HI;
                    end
                end
            end
            HI: begin
                timer_enable = 1'b1;
                if (bus.rx_valid) begin
                    latch_hi   = 1'b1;
                    next_state = LO;
                end else if (timer_expired) begin
                    next_state = ERROR;
                end
            end
            LO: begin
                timer_enable = 1'b1;
                if (bus.rx_valid) begin
                    write_word = 1'b1;
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        next_state = CSUM;
`else
                        next_state = DONE;
`endif
                    end else begin
                        next_state = HI;
                    end
                end else if (timer_expired) begin
                    next_state = ERROR;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                timer_enable = 1'b1;
                if (bus.rx_valid) begin
                    next_state = (bus.rx_data == csum_q) ? DONE : ERROR;
                end else if (timer_expired) begin
                    next_state = ERROR;
                end
            end
`endif
            DONE:    next_state = DONE;
            ERROR:   next_state = ERROR;
            default: next_state = IDLE;
        endcase
        if (bus.reload) begin
            next_state   = IDLE;
            accept_count = 1'b0;
            latch_hi     = 1'b0;
            write_word   = 1'b0;
        end
    end

    // datapath: word count, high byte, registered write port and word counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_n        <= '0;
            hi_byte        <= '0;
            words_loaded_q <= '0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
        end else begin
            we_q <= write_word;
            if (bus.reload) begin
                words_loaded_q <= '0;
            end else if (accept_count) begin
                count_n        <= bus.rx_data;
                words_loaded_q <= '0;
            end else if (we_q) begin
                words_loaded_q <= words_loaded_q + WW'(1);
            end
            if (latch_hi) begin
                hi_byte <= bus.rx_data;
            end
            if (write_word) begin
                addr_q  <= words_loaded_q[AW-1:0];
                wdata_q <= {hi_byte, bus.rx_data};
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // running XOR of the count byte and every data byte
    always_ff @(posedge CLK) begin
        if (RST) begin
            csum_q <= '0;
        end else if (accept_count) begin
            csum_q <= bus.rx_data;
        end else if (latch_hi || write_word) begin
            csum_q <= csum_q ^ bus.rx_data;
        end
    end
`endif

    assign bus.imem_we      = we_q;
    assign bus.imem_addr    = addr_q;
    assign bus.imem_wdata   = wdata_q;
    assign bus.words_loaded = words_loaded_q;
    assign bus.load_done    = (state == DONE);
    assign bus.load_error   = (state == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a vector table, a few
// hand-written corner sequences and randomized loads against a
// byte-stream model. Honours LOADER_CHECKSUM_EN when defined.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int T = 16;

    typedef struct {
        int          nb;
        logic [7:0]  b [6];
        int          gap_idx;
        int          gap_len;
        logic        exp_done;
        logic        exp_err;
        int          exp_words;
        int          exp_nw;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs [$];
    logic [20:0] wq [$];

    program_loader_if bus_if ();

    program_loader #(
        .IMEM_DEPTH     (32),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if)
    );

    always #5 CLK = ~CLK;

    // record every instruction-memory write, sampled mid-cycle
    always @(negedge CLK) begin
        if (bus_if.imem_we === 1'b1) wq.push_back({bus_if.imem_addr, bus_if.imem_wdata});
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge CLK);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        @(negedge CLK);
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic doReload();
        bus_if.reload = 1'b1;
        @(negedge CLK);
        bus_if.reload = 1'b0;
        @(negedge CLK);
        wq.delete();
    endtask

    task automatic checkWrites(input string tag, input int nw, input logic [15:0] w [$]);
        logic [20:0] e;
        checkOutput({tag, "_nwrites"}, 32'(wq.size()), 32'(nw));
        for (int j = 0; j < nw && j < wq.size(); j++) begin
            e = wq[j];
            checkOutput({tag, "_addr"}, 32'(e[20:16]), 32'(j));
            checkOutput({tag, "_data"}, 32'(e[15:0]), 32'(w[j]));
        end
    endtask

    task automatic checkStatus(input string tag, input logic done, input logic err, input int words);
        checkOutput({tag, "_done"},  32'(bus_if.load_done),    32'(done));
        checkOutput({tag, "_error"}, 32'(bus_if.load_error),   32'(err));
        checkOutput({tag, "_words"}, 32'(bus_if.words_loaded), 32'(words));
    endtask

    task automatic addVec(input int nb, input logic [7:0] b0, b1, b2, b3, b4, b5,
                          input int gi, input int gl, input logic d, input logic e,
                          input int words, input int nw, input logic [15:0] w0, input logic [15:0] w1);
        vec_t v;
        v.nb = nb;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4; v.b[5] = b5;
        v.gap_idx = gi; v.gap_len = gl;
        v.exp_done = d; v.exp_err = e; v.exp_words = words; v.exp_nw = nw;
        v.w0 = w0; v.w1 = w1;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input int idx);
        vec_t v = vecs[idx];
        logic [15:0] w [$];
        doReload();
        for (int i = 0; i < v.nb; i++) sendByte(v.b[i], (i == v.gap_idx) ? v.gap_len : 0);
        repeat (3) @(negedge CLK);
        w.push_back(v.w0);
        w.push_back(v.w1);
        checkStatus($sformatf("vec%0d", idx), v.exp_done, v.exp_err, v.exp_words);
        checkWrites($sformatf("vec%0d", idx), v.exp_nw, w);
        doReload();
        checkStatus($sformatf("vec%0d_reload", idx), 1'b0, 1'b0, 0);
    endtask

    // one random load judged by a byte-stream model: a gap of T or more idle
    // cycles before any byte after the count aborts the load at that byte
    task automatic randomLoad(input int iter);
        int n, needed, fail_at, words, r;
        logic exp_err, exp_done;
        logic [7:0] xs;
        logic [7:0] d [$];
        int gaps [$];
        logic [15:0] w [$];
        r = int'($urandom_range(0, 9));
        if (r == 0) n = 0;
        else if (r == 1) n = int'($urandom_range(33, 255));
        else n = int'($urandom_range(1, 5));
        needed = (n == 0 || n > 32) ? 0 : 2 * n;
`ifdef LOADER_CHECKSUM_EN
        if (needed > 0) needed++;
`endif
        xs = 8'(n);
        for (int k = 0; k < needed; k++) begin
            d.push_back(8'($urandom_range(0, 255)));
            r = int'($urandom_range(0, 19));
            gaps.push_back(r == 0 ? T : (r == 1 ? T - 1 : int'($urandom_range(0, 2))));
        end
`ifdef LOADER_CHECKSUM_EN
        if (needed > 0) begin
            for (int k = 0; k < needed - 1; k++) xs = xs ^ d[k];
            d[needed-1] = ($urandom_range(0, 3) == 0) ? ~xs : xs;
        end
`endif
        fail_at = -1;
        for (int k = 0; k < needed; k++) begin
            if (gaps[k] >= T) begin
                fail_at = k;
                break;
            end
        end
        if (needed == 0) begin
            exp_err = 1'b1; words = 0;
        end else if (fail_at >= 0) begin
            exp_err = 1'b1; words = fail_at / 2;
        end else begin
            words = n;
            exp_err = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            exp_err = (d[needed-1] != xs);
`endif
        end
        exp_done = !exp_err;
        for (int i = 0; i < words; i++) w.push_back({d[2*i], d[2*i+1]});

        doReload();
        sendByte(8'(n), int'($urandom_range(0, 3)));
        for (int k = 0; k < needed; k++) sendByte(d[k], gaps[k]);
        sendByte(8'($urandom_range(0, 255)), 0);
        repeat (3) @(negedge CLK);
        checkStatus($sformatf("rnd%0d", iter), exp_done, exp_err, words);
        checkWrites($sformatf("rnd%0d", iter), words, w);
    endtask

    initial begin
        logic [15:0] w [$];
        RST = 1'b1;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.reload   = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("rst_we",    32'(bus_if.imem_we),    32'd0);
        checkOutput("rst_addr",  32'(bus_if.imem_addr),  32'd0);
        checkOutput("rst_wdata", 32'(bus_if.imem_wdata), 32'd0);
        checkStatus("rst", 1'b0, 1'b0, 0);
        RST = 1'b0;
        @(negedge CLK);

`ifdef LOADER_CHECKSUM_EN
        addVec(4, 8'h01, 8'h12, 8'h34, 8'h27, 8'h00, 8'h00, -1, 0, 1'b1, 1'b0, 1, 1, 16'h1234, 16'h0000);
        addVec(4, 8'h01, 8'h12, 8'h34, 8'h26, 8'h00, 8'h00, -1, 0, 1'b0, 1'b1, 1, 1, 16'h1234, 16'h0000);
        addVec(1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, -1, 0, 1'b0, 1'b1, 0, 0, 16'h0000, 16'h0000);
        addVec(1, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, -1, 0, 1'b0, 1'b1, 0, 0, 16'h0000, 16'h0000);
        addVec(4, 8'h01, 8'h12, 8'h34, 8'h27, 8'h00, 8'h00,  3, T, 1'b0, 1'b1, 1, 1, 16'h1234, 16'h0000);
`else
        addVec(5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, -1, 0, 1'b1, 1'b0, 2, 2, 16'h1234, 16'hABCD);
        addVec(1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, -1, 0, 1'b0, 1'b1, 0, 0, 16'h0000, 16'h0000);
        addVec(1, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, -1, 0, 1'b0, 1'b1, 0, 0, 16'h0000, 16'h0000);
        addVec(3, 8'h01, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00,  2, T, 1'b0, 1'b1, 0, 0, 16'h0000, 16'h0000);
        addVec(3, 8'h01, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00,  2, T - 1, 1'b1, 1'b0, 1, 1, 16'h1234, 16'h0000);
        addVec(5, 8'h01, 8'hAA, 8'hBB, 8'h55, 8'h66, 8'h00, -1, 0, 1'b1, 1'b0, 1, 1, 16'hAABB, 16'h0000);
        addVec(4, 8'h00, 8'h01, 8'h12, 8'h34, 8'h00, 8'h00, -1, 0, 1'b0, 1'b1, 0, 0, 16'h0000, 16'h0000);
`endif
        for (int i = 0; i < vecs.size(); i++) applyStimulus(i);

        // write strobe follows the low byte by one cycle and lasts one cycle
        doReload();
        sendByte(8'h01, 0);
        sendByte(8'hAA, 0);
        checkOutput("lat_we_before", 32'(bus_if.imem_we), 32'd0);
        sendByte(8'hBB, 0);
        checkOutput("lat_we_after", 32'(bus_if.imem_we), 32'd1);
        @(negedge CLK);
        checkOutput("lat_we_single", 32'(bus_if.imem_we), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        sendByte(8'h10, 0);
`endif
        repeat (2) @(negedge CLK);
        checkOutput("hold_addr",  32'(bus_if.imem_addr),  32'd0);
        checkOutput("hold_wdata", 32'(bus_if.imem_wdata), 32'hAABB);
        checkStatus("lat", 1'b1, 1'b0, 1);

        // reset in the middle of a load abandons it
        doReload();
        sendByte(8'h03, 0);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        RST = 1'b1;
        @(negedge CLK);
        wq.delete();
        checkOutput("mrst_we",    32'(bus_if.imem_we),    32'd0);
        checkOutput("mrst_addr",  32'(bus_if.imem_addr),  32'd0);
        checkOutput("mrst_wdata", 32'(bus_if.imem_wdata), 32'd0);
        checkStatus("mrst", 1'b0, 1'b0, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("mrst_nowrite", 32'(wq.size()), 32'd0);
        sendByte(8'h01, 0);
        sendByte(8'hAA, 0);
        sendByte(8'hBB, 0);
`ifdef LOADER_CHECKSUM_EN
        sendByte(8'h10, 0);
`endif
        repeat (2) @(negedge CLK);
        w.delete();
        w.push_back(16'hAABB);
        checkWrites("mrst_fresh", 1, w);
        checkStatus("mrst_fresh", 1'b1, 1'b0, 1);

        // reload together with the low byte drops the byte and the write
        doReload();
        sendByte(8'h01, 0);
        sendByte(8'h12, 0);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h34;
        bus_if.reload   = 1'b1;
        @(negedge CLK);
        bus_if.rx_valid = 1'b0;
        bus_if.reload   = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("rl_nowrite", 32'(wq.size()), 32'd0);
        checkStatus("rl", 1'b0, 1'b0, 0);
        sendByte(8'h01, 0);
        sendByte(8'h56, 0);
        sendByte(8'h78, 0);
`ifdef LOADER_CHECKSUM_EN
        sendByte(8'h2F, 0);
`endif
        repeat (2) @(negedge CLK);
        w.delete();
        w.push_back(16'h5678);
        checkWrites("rl_next", 1, w);
        checkStatus("rl_next", 1'b1, 1'b0, 1);

        for (int i = 0; i < 40; i++) randomLoad(i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
